// File: rtl/calc_pkg.sv
// Shared types and display tables for the calc_seq push-button calculator.
package calc_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } op_e;

  localparam logic [3:0] OP_LAST = 4'd9;

  localparam int FLG_ERR   = 4;
  localparam int FLG_NEG   = 3;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;

  function automatic logic [7:0] op_glyph(input logic [3:0] code);
    case (code)
      4'd0:    op_glyph = 8'b01001001;
      4'd1:    op_glyph = 8'b11111101;
      4'd2:    op_glyph = 8'b10010001;
      4'd3:    op_glyph = 8'b10000101;
      4'd4:    op_glyph = 8'b10110101;
      4'd5:    op_glyph = 8'b00010011;
      4'd6:    op_glyph = 8'b10000011;
      4'd7:    op_glyph = 8'b10101001;
      4'd8:    op_glyph = 8'b01100011;
      4'd9:    op_glyph = 8'b00001111;
      default: op_glyph = SEG_BLANK;
    endcase
  endfunction

  // Active-low segments, bit order {dp, g, f, e, d, c, b, a}.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_glyph = 8'hC0;
      4'h1:    hex_glyph = 8'hF9;
      4'h2:    hex_glyph = 8'hA4;
      4'h3:    hex_glyph = 8'hB0;
      4'h4:    hex_glyph = 8'h99;
      4'h5:    hex_glyph = 8'h92;
      4'h6:    hex_glyph = 8'h82;
      4'h7:    hex_glyph = 8'hF8;
      4'h8:    hex_glyph = 8'h80;
      4'h9:    hex_glyph = 8'h90;
      4'hA:    hex_glyph = 8'h88;
      4'hB:    hex_glyph = 8'h83;
      4'hC:    hex_glyph = 8'hC6;
      4'hD:    hex_glyph = 8'hA1;
      4'hE:    hex_glyph = 8'h86;
      default: hex_glyph = 8'h8E;
    endcase
  endfunction

endpackage

// File: rtl/calc_debounce.sv
// Two-flop synchroniser plus counting debouncer; one-cycle pulse per accepted rising level.
// Pulse appears 2 + DEB_CYCLES clocks after the raw input settles high.
module calc_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, pulse_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      // Any sample agreeing with the accepted level restarts the run.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        pulse_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/calc_div.sv
// Restoring divider, one quotient bit per clock; the start cycle already computes the first bit,
// so done_o is high on the WIDTH-th cycle after start with final quotient/remainder.
module calc_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  logic [WIDTH-1:0] src_quo, src_rem, step_quo, step_rem;
  logic [WIDTH:0]   trial, diff;
  logic             qbit;

  always_comb begin
    src_quo  = start_i ? dividend_i : quo_q;
    src_rem  = start_i ? '0 : rem_q;
    trial    = {src_rem, src_quo[WIDTH-1]};
    diff     = trial - {1'b0, divisor_i};
    qbit     = (trial >= {1'b0, divisor_i});
    step_rem = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    step_quo = {src_quo[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      quo_q <= step_quo;
      rem_q <= step_rem;
      cnt_q <= CW'(WIDTH - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        quo_q <= step_quo;
        rem_q <= step_rem;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign done_o      = run_q && (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/calc_seq.sv
// Push-button sequential calculator: sig cycles the operation, equ executes it on latched a/b.
// Result valid 2 clocks after the equ pulse (WIDTH+2 for divide/modulo); buttons ignored while busy.
module calc_seq
  import calc_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           sig,
  input  logic                           equ,
  output logic [3:0]                     op,
  output logic [WIDTH-1:0]               result,
  output logic [4:0]                     flag,
  output logic                           busy,
  output logic                           valid,
  output logic [7:0]                     seg_op,
  output logic [8*((WIDTH+3)/4)-1:0]     seg_res
);

  localparam int NDIG = (WIDTH + 3) / 4;

  logic sig_p, equ_p;

  calc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sig (
    .clk(clk), .rst_n(rst_n), .btn_i(sig), .pulse_o(sig_p)
  );

  calc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_equ (
    .clk(clk), .rst_n(rst_n), .btn_i(equ), .pulse_o(equ_p)
  );

  state_e           state_q;
  logic [3:0]       op_q, xop_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [4:0]       flag_q;
  logic             busy_q, valid_q, shown_q;

  logic             is_div, div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem, div_res;
  logic [4:0]       div_flag;

  assign is_div    = (xop_q == OP_DIV) || (xop_q == OP_MOD);
  assign div_start = (state_q == ST_EXEC) && is_div && (b_q != '0);

  calc_div #(.WIDTH(WIDTH)) u_div (
    .clk(clk), .rst_n(rst_n), .start_i(div_start),
    .dividend_i(a_q), .divisor_i(b_q),
    .done_o(div_done), .quotient_o(div_quo), .remainder_o(div_rem)
  );

  logic [WIDTH:0]     sum_d, diff_d;
  logic [2*WIDTH-1:0] prod_d, shl_d, shr_d;
  logic               big_shift;
  logic [WIDTH-1:0]   alu_res_d;
  logic [4:0]         alu_flag_d;
  logic               carry_d, ovf_d, err_d;

  always_comb begin
    sum_d     = {1'b0, a_q} + {1'b0, b_q};
    diff_d    = {1'b0, a_q} - {1'b0, b_q};
    prod_d    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    shl_d     = {{WIDTH{1'b0}}, a_q} << b_q;
    shr_d     = {a_q, {WIDTH{1'b0}}} >> b_q;
    big_shift = ({1'b0, b_q} >= (WIDTH+1)'(WIDTH));
    alu_res_d = '0;
    carry_d   = 1'b0;
    ovf_d     = 1'b0;
    err_d     = 1'b0;
    case (xop_q)
      OP_ADD: begin
        alu_res_d = sum_d[WIDTH-1:0];
        carry_d   = sum_d[WIDTH];
        ovf_d     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_d = diff_d[WIDTH-1:0];
        carry_d   = diff_d[WIDTH];
        ovf_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        alu_res_d = prod_d[WIDTH-1:0];
        carry_d   = |prod_d[2*WIDTH-1:WIDTH];
        ovf_d     = |prod_d[2*WIDTH-1:WIDTH];
      end
      // Only reached here with b == 0; a nonzero divisor goes through the divider.
      OP_DIV, OP_MOD: err_d = 1'b1;
      OP_AND: alu_res_d = a_q & b_q;
      OP_OR:  alu_res_d = a_q | b_q;
      OP_XOR: alu_res_d = a_q ^ b_q;
      OP_SHL: begin
        alu_res_d = big_shift ? '0 : shl_d[WIDTH-1:0];
        carry_d   = big_shift ? |a_q : |shl_d[2*WIDTH-1:WIDTH];
      end
      OP_SHR: begin
        alu_res_d = big_shift ? '0 : shr_d[2*WIDTH-1:WIDTH];
        carry_d   = big_shift ? |a_q : |shr_d[WIDTH-1:0];
      end
      default: alu_res_d = '0;
    endcase

    alu_flag_d = '0;
    if (err_d) begin
      alu_flag_d[FLG_ERR] = 1'b1;
    end else begin
      alu_flag_d[FLG_NEG]   = alu_res_d[WIDTH-1];
      alu_flag_d[FLG_ZERO]  = (alu_res_d == '0);
      alu_flag_d[FLG_CARRY] = carry_d;
      alu_flag_d[FLG_OVF]   = ovf_d;
    end

    div_res            = (xop_q == OP_DIV) ? div_quo : div_rem;
    div_flag           = '0;
    div_flag[FLG_NEG]  = div_res[WIDTH-1];
    div_flag[FLG_ZERO] = (div_res == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      xop_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flag_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      shown_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // equ wins over a coincident sig.
          if (equ_p) begin
            a_q     <= a;
            b_q     <= b;
            xop_q   <= op_q;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end else if (sig_p) begin
            op_q <= (op_q == OP_LAST) ? 4'd0 : op_q + 4'd1;
          end
        end
        ST_EXEC: begin
          if (div_start) begin
            state_q <= ST_DIV;
          end else begin
            result_q <= alu_res_d;
            flag_q   <= alu_flag_d;
            valid_q  <= 1'b1;
            shown_q  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            result_q <= div_res;
            flag_q   <= div_flag;
            valid_q  <= 1'b1;
            shown_q  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [4*NDIG-1:0] res_pad;

  always_comb begin
    res_pad                = '0;
    res_pad[WIDTH-1:0]     = result_q;
    seg_res                = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (!shown_q) begin
        seg_res[8*i +: 8] = SEG_BLANK;
      end else if (flag_q[FLG_ERR]) begin
        seg_res[8*i +: 8] = (i == 0) ? SEG_E : SEG_BLANK;
      end else begin
        seg_res[8*i +: 8] = hex_glyph(res_pad[4*i +: 4]);
      end
    end
  end

  assign op     = op_q;
  assign result = result_q;
  assign flag   = flag_q;
  assign busy   = busy_q;
  assign valid  = valid_q;
  assign seg_op = op_glyph(op_q);

endmodule

// File: tb/tb_calc_seq.sv
// Scoreboard bench for calc_seq at WIDTH=4, DEB_CYCLES=4.
module tb_calc_seq;

  localparam int W           = 4;
  localparam int DEB         = 4;
  localparam int PULSE_EDGES = 2 + DEB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         sig = 1'b0, equ = 1'b0;
  logic [3:0]   op;
  logic [W-1:0] result;
  logic [4:0]   flag;
  logic         busy, valid;
  logic [7:0]   seg_op;
  logic [7:0]   seg_res;

  calc_seq #(.WIDTH(W), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sig(sig), .equ(equ),
    .op(op), .result(result), .flag(flag), .busy(busy), .valid(valid),
    .seg_op(seg_op), .seg_res(seg_res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   flg;
    int           at;
    int           blen;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc = 0;
  int  blen = 0;
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  cur_op = 0;

  logic [7:0] op_gl [10] = '{8'b01001001, 8'b11111101, 8'b10010001, 8'b10000101, 8'b10110101,
                             8'b00010011, 8'b10000011, 8'b10101001, 8'b01100011, 8'b00001111};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    blen <= busy ? blen + 1 : 0;
    if (valid) obs_q.push_back('{result, flag, cyc, blen + 1});
  end

  function automatic void model(input int opc, input int av, input int bv,
                                output logic [W-1:0] r, output logic [4:0] f);
    int res, full, sa, sb, m;
    bit c, v, e;
    m = 1 << W;
    res = 0; c = 0; v = 0; e = 0;
    sa = (av >= m/2) ? av - m : av;
    sb = (bv >= m/2) ? bv - m : bv;
    case (opc)
      0: begin full = av + bv; res = full % m; c = full >= m; v = (sa+sb > m/2-1) || (sa+sb < -m/2); end
      1: begin full = av - bv; res = (full + m) % m; c = av < bv; v = (sa-sb > m/2-1) || (sa-sb < -m/2); end
      2: begin full = av * bv; res = full % m; c = full >= m; v = c; end
      3: if (bv == 0) e = 1; else res = av / bv;
      4: if (bv == 0) e = 1; else res = av % bv;
      5: res = av & bv;
      6: res = av | bv;
      7: res = av ^ bv;
      8: if (bv >= W) begin c = av != 0; end else begin full = av << bv; res = full % m; c = full >= m; end
      9: if (bv >= W) begin c = av != 0; end else begin res = av >> bv; c = (av % (1 << bv)) != 0; end
      default: res = 0;
    endcase
    r = res[W-1:0];
    f = e ? 5'b10000 : {1'b0, r[W-1], r == '0, c, v};
  endfunction

  task automatic press_sig(input int hold);
    @(negedge clk) sig = 1'b1;
    repeat (hold) @(negedge clk);
    sig = 1'b0;
    repeat (PULSE_EDGES + 4) @(negedge clk);
  endtask

  task automatic set_op(input int target);
    while (cur_op != target) begin
      press_sig(6);
      cur_op = (cur_op + 1) % 10;
    end
  endtask

  task automatic run_calc(input int opc, input int av, input int bv,
                          input logic [W-1:0] er, input logic [4:0] ef);
    int lat;
    set_op(opc);
    lat = ((opc == 3 || opc == 4) && bv != 0) ? W + 2 : 2;
    @(negedge clk);
    a = W'(av); b = W'(bv); equ = 1'b1;
    exp_q.push_back('{er, ef, cyc + PULSE_EDGES + lat, lat});
    repeat (6) @(negedge clk);
    equ = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (op !== 4'd0) $display("FAIL reset_op: got %0d want 0", op); else pass_cnt++;
    total_cnt++; if (result !== '0) $display("FAIL reset_result: got %0h want 0", result); else pass_cnt++;
    total_cnt++; if (flag !== 5'b0) $display("FAIL reset_flag: got %b want 00000", flag); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL reset_busy_valid: got %b%b want 00", busy, valid); else pass_cnt++;
    total_cnt++; if (seg_op !== 8'b01001001) $display("FAIL reset_seg_op: got %b want 01001001", seg_op); else pass_cnt++;
    total_cnt++; if (seg_res !== 8'hFF) $display("FAIL reset_seg_res: got %h want ff", seg_res); else pass_cnt++;
  endtask

  task automatic test_add;
    ev_t e, o;
    run_calc(0, 3, 5, 4'd8, 5'b01001);
    total_cnt++; if (seg_res !== 8'h80) $display("FAIL add_seg_res: got %h want 80", seg_res); else pass_cnt++;
    // sig and equ together: execution taken, op not advanced
    @(negedge clk);
    a = 4'd7; b = 4'd2; sig = 1'b1; equ = 1'b1;
    exp_q.push_back('{4'd9, 5'b01001, cyc + PULSE_EDGES + 2, 2});
    repeat (6) @(negedge clk);
    sig = 1'b0; equ = 1'b0;
    repeat (30) @(negedge clk);
    total_cnt++; if (op !== 4'd0) $display("FAIL coincide_op: got %0d want 0", op); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL add_valid: no valid, want res=%0h", e.res);
      else begin
        o = obs_q.pop_front();
        if (o.res !== e.res || o.flg !== e.flg || o.at !== e.at || o.blen !== e.blen)
          $display("FAIL add_result: got res=%0h flg=%b at=%0d busy=%0d want res=%0h flg=%b at=%0d busy=%0d",
                   o.res, o.flg, o.at, o.blen, e.res, e.flg, e.at, e.blen);
        else pass_cnt++;
      end
    end
    total_cnt++; if (obs_q.size() != 0) $display("FAIL add_extra_valid: got %0d extra want 0", obs_q.size()); else pass_cnt++;
    obs_q.delete();
  endtask

  task automatic test_op_step;
    for (int i = 1; i <= 10; i++) begin
      press_sig(6);
      cur_op = (cur_op + 1) % 10;
      total_cnt++; if (op !== 4'(cur_op)) $display("FAIL op_step%0d: got %0d want %0d", i, op, cur_op); else pass_cnt++;
      total_cnt++; if (seg_op !== op_gl[cur_op]) $display("FAIL seg_op%0d: got %b want %b", i, seg_op, op_gl[cur_op]); else pass_cnt++;
    end
    press_sig(3);
    total_cnt++; if (op !== 4'(cur_op)) $display("FAIL glitch_op: got %0d want %0d", op, cur_op); else pass_cnt++;
    press_sig(4);
    cur_op = (cur_op + 1) % 10;
    total_cnt++; if (op !== 4'(cur_op)) $display("FAIL min_press_op: got %0d want %0d", op, cur_op); else pass_cnt++;
  endtask

  task automatic test_div;
    ev_t e, o;
    run_calc(3, 13, 4, 4'd3, 5'b00000);
    run_calc(4, 13, 4, 4'd1, 5'b00000);
    run_calc(3, 13, 0, 4'd0, 5'b10000);
    total_cnt++; if (seg_res !== 8'h86) $display("FAIL div0_seg_res: got %h want 86", seg_res); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL div_valid: no valid, want res=%0h", e.res);
      else begin
        o = obs_q.pop_front();
        if (o.res !== e.res || o.flg !== e.flg || o.at !== e.at || o.blen !== e.blen)
          $display("FAIL div_result: got res=%0h flg=%b at=%0d busy=%0d want res=%0h flg=%b at=%0d busy=%0d",
                   o.res, o.flg, o.at, o.blen, e.res, e.flg, e.at, e.blen);
        else pass_cnt++;
      end
    end
    total_cnt++; if (obs_q.size() != 0) $display("FAIL div_extra_valid: got %0d extra want 0", obs_q.size()); else pass_cnt++;
    obs_q.delete();
  endtask

  task automatic test_shift_and_table;
    ev_t e, o;
    logic [W-1:0] er;
    logic [4:0]   ef;
    int tbl [14][3] = '{'{8,3,5}, '{9,9,1}, '{1,3,5}, '{1,8,1}, '{2,5,7}, '{2,3,3}, '{5,12,10},
                        '{6,5,10}, '{7,15,15}, '{0,7,1}, '{0,15,1}, '{3,15,2}, '{4,7,7}, '{9,8,4}};
    run_calc(8, 3, 5, 4'd0, 5'b00110);
    run_calc(9, 9, 1, 4'd4, 5'b00010);
    for (int i = 2; i < 14; i++) begin
      model(tbl[i][0], tbl[i][1], tbl[i][2], er, ef);
      run_calc(tbl[i][0], tbl[i][1], tbl[i][2], er, ef);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL table_valid: no valid, want res=%0h", e.res);
      else begin
        o = obs_q.pop_front();
        if (o.res !== e.res || o.flg !== e.flg || o.at !== e.at || o.blen !== e.blen)
          $display("FAIL table_result: got res=%0h flg=%b at=%0d busy=%0d want res=%0h flg=%b at=%0d busy=%0d",
                   o.res, o.flg, o.at, o.blen, e.res, e.flg, e.at, e.blen);
        else pass_cnt++;
      end
    end
    total_cnt++; if (obs_q.size() != 0) $display("FAIL table_extra_valid: got %0d extra want 0", obs_q.size()); else pass_cnt++;
    obs_q.delete();
  endtask

  task automatic test_busy_ignore;
    ev_t e, o;
    bit seen;
    set_op(3);
    @(negedge clk);
    a = 4'd13; b = 4'd4; equ = 1'b1;
    exp_q.push_back('{4'd3, 5'b00000, cyc + PULSE_EDGES + W + 2, W + 2});
    // sig rises 3 clocks later so its pulse lands mid-division
    repeat (3) @(negedge clk);
    sig = 1'b1;
    repeat (3) @(negedge clk);
    equ = 1'b0;
    repeat (5) @(negedge clk);
    sig = 1'b0;
    repeat (30) @(negedge clk);
    total_cnt++; if (op !== 4'd3) $display("FAIL busy_sig_op: got %0d want 3", op); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL busy_valid: no valid, want res=%0h", e.res);
      else begin
        o = obs_q.pop_front();
        if (o.res !== e.res || o.flg !== e.flg || o.at !== e.at || o.blen !== e.blen)
          $display("FAIL busy_result: got res=%0h flg=%b at=%0d busy=%0d want res=%0h flg=%b at=%0d busy=%0d",
                   o.res, o.flg, o.at, o.blen, e.res, e.flg, e.at, e.blen);
        else pass_cnt++;
      end
    end
    total_cnt++; if (obs_q.size() != 0) $display("FAIL busy_extra_valid: got %0d extra want 0", obs_q.size()); else pass_cnt++;
    obs_q.delete();

    // Reset while dividing: no valid, everything back to reset values
    @(negedge clk);
    a = 4'd15; b = 4'd3; equ = 1'b1;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    total_cnt++; if (!seen) $display("FAIL midreset_busy: got busy=0 want 1 within 40 cycles"); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; equ = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cur_op = 0;
    repeat (30) @(negedge clk);
    total_cnt++; if (obs_q.size() != 0) $display("FAIL midreset_valid: got %0d pulses want 0", obs_q.size()); else pass_cnt++;
    total_cnt++; if (result !== '0 || flag !== 5'b0) $display("FAIL midreset_result: got %0h/%b want 0/00000", result, flag); else pass_cnt++;
    total_cnt++; if (op !== 4'd0 || busy !== 1'b0) $display("FAIL midreset_state: got op=%0d busy=%b want 0/0", op, busy); else pass_cnt++;
    total_cnt++; if (seg_res !== 8'hFF) $display("FAIL midreset_seg_res: got %h want ff", seg_res); else pass_cnt++;
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_add();
    test_op_step();
    test_div();
    test_shift_and_table();
    test_busy_ignore();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width (range 4..16).
REQ-002 SHALL have parameter DEB_CYCLES, default 4, clocks a synchronised button must stay stable before it is accepted.
REQ-003 SHALL have ports: clk  in  1  single clock; rising edge.
REQ-004 SHALL have ports: rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: a, b  in  WIDTH  operands; asynchronous switches.
REQ-006 SHALL have ports: sig, equ  in  1  raw push buttons, active-high; sig advances the operation, equ executes it.
REQ-007 SHALL have ports: op  out  4  current operation code, 0..9.
REQ-008 SHALL have ports: result  out  WIDTH  last completed result.
REQ-009 SHALL have ports: flag  out  5  flags of the last completed result: [4] err, [3] neg, [2] zero, [1] carry, [0] overflow.
REQ-010 SHALL have ports: busy  out  1  high while an execution is in progress.
REQ-011 SHALL have ports: valid  out  1  one-cycle pulse when result/flag update.
REQ-012 SHALL have ports: seg_op  out  8  active-low 7-seg glyph of op.
REQ-013 SHALL have ports: seg_res  out  8*NDIG  active-low hex digits of result, NDIG=ceil(WIDTH/4), digit 0 in the LSBs.

Function
REQ-014 Each button SHALL pass a 2-flop synchroniser, then a debouncer that accepts a level only after DEB_CYCLES identical consecutive samples; each accepted 0->1 transition SHALL give exactly one internal one-cycle pulse.
REQ-015 A sig pulse in IDLE SHALL advance op by 1, wrapping 9->0; sig pulses SHALL be ignored while busy.
REQ-016 If sig and equ pulses coincide, equ SHALL be taken and sig dropped.
REQ-017 The FSM SHALL have states IDLE, EXEC, DIV, DONE.
REQ-018 IDLE + equ pulse -> EXEC; a, b and op SHALL be latched at that edge.
REQ-019 EXEC -> DIV for op 3/4 with nonzero b; otherwise EXEC -> DONE.
REQ-020 DIV SHALL run a restoring divider for exactly WIDTH cycles, then go to DONE.
REQ-021 DONE SHALL register result and flag, pulse valid for one cycle, then return to IDLE.
REQ-022 busy SHALL be high in EXEC, DIV and DONE; equ pulses while busy SHALL be dropped.
REQ-023 Latency from equ pulse to valid SHALL be 2 cycles for non-divide ops and WIDTH+2 for op 3/4.
REQ-024 Ops SHALL be: 0 add, 1 sub, 2 mul (low WIDTH bits), 3 div, 4 mod, 5 and, 6 or, 7 xor, 8 a<<b, 9 a>>b (logical). A shift by b>=WIDTH SHALL give 0.
REQ-025 neg SHALL equal the result MSB; zero SHALL equal (result==0).
REQ-026 carry SHALL be: add carry-out; sub borrow (a<b); mul nonzero upper half; shifts any 1 shifted out; 0 otherwise.
REQ-027 overflow SHALL be two's-complement overflow for add/sub, equal to carry for mul, and 0 otherwise.
REQ-028 Div/mod by b==0 SHALL skip DIV and give result 0, flag 5'b10000.
REQ-029 seg_op SHALL be combinational from op; codes outside 0..9 SHALL display blank 8'hFF.
REQ-030 seg_res SHALL be all 8'hFF until the first valid; afterwards it SHALL show hex of result, and when flag[4] is set, digit 0 SHALL show 'E' with the other digits blank.

Reset
REQ-031 With rst_n low at a clock edge, the block SHALL set: state IDLE, op 0, result 0, flag 0, busy 0, valid 0, synchroniser/debounce state cleared (button considered low), seg_res blank.
REQ-032 A reset mid-DIV SHALL abort the division with no valid pulse.

Structure
REQ-033 The shared package calc_pkg SHALL hold: op code enum, flag bit indices, FSM state enum, seg_op glyph table (+ 01001001, - 11111101, * 10010001, / 10000101, % 10110101, and 00010011, or 10000011, xor 10101001, << 01100011, >> 00001111), and the hex glyph table.
REQ-034 The iterative divider SHALL be a sub-module calc_div (start, done, quotient, remainder); the debouncer SHALL be instantiated twice as calc_debounce.

Verification (WIDTH=4, DEB_CYCLES=4)
REQ-035 Reset -> op=0, result=0, flag=0, seg_op=01001001, seg_res=FF.
REQ-036 op=0, a=3, b=5, press equ -> result=8, flag=01001, valid exactly once, 2 cycles after the pulse.
REQ-037 Ten sig presses -> op steps 1..9 then 0; a glitch shorter than 4 cycles -> op unchanged.
REQ-038 op=3, a=13, b=4 -> result=3 after 6 cycles, busy high throughout; op=4 -> result=1; b=0 -> result=0, flag=10000, 2 cycles.
REQ-039 sig and equ pressed during DIV -> op unchanged, no extra execution; rst_n low mid-DIV -> IDLE, no valid pulse, result=0.
REQ-040 op=8, a=3, b=5 -> result=0, flag=00110; op=9, a=9, b=1 -> result=4, flag=00010.
